// File: rtl/riscv_test_monitor.sv
// Bench-side monitor for riscv-tests programs: decodes the tohost completion
// write and runs a cycle watchdog plus PC-stall detector to give a registered verdict.
module riscv_test_monitor #(
  parameter logic [31:0] TOHOST_ADDR    = 32'h0000_1000,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned STALL_CYCLES   = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        memWr,
  input  logic [31:0] memAddr,
  input  logic [31:0] memIn,
  input  logic [3:0]  wrMask,
  input  logic [31:0] PC,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timeout,
  output logic        hang,
  output logic [30:0] testNum,
  output logic [31:0] cycleCount
);

  localparam int unsigned STALL_W = $clog2(STALL_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_PASS,
    S_FAIL,
    S_TIMEOUT
  } state_t;

  state_t               state_q, state_d;
  logic [31:0]          cyc_q, cyc_d;
  logic [30:0]          tn_q, tn_d;
  logic [STALL_W-1:0]   stall_q, stall_d;
  logic [31:0]          last_pc_q, last_pc_d;
  logic                 hang_q, hang_d;
  logic                 done_q, pass_q, fail_q, timeout_q;
  logic                 tohost_store;
  logic                 pc_same;

  assign tohost_store = memWr && (memAddr == TOHOST_ADDR) && (wrMask == 4'b1111);
  assign pc_same      = (PC == last_pc_q);

  // Next-state: start overrides everything; in RUN verdict store > watchdog > stall.
  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    tn_d      = tn_q;
    stall_d   = stall_q;
    last_pc_d = last_pc_q;
    hang_d    = hang_q;
    if (start) begin
      state_d   = S_RUN;
      cyc_d     = 32'd0;
      tn_d      = 31'd0;
      stall_d   = '0;
      last_pc_d = PC;
      hang_d    = 1'b0;
    end else if (state_q == S_RUN) begin
      last_pc_d = PC;
      stall_d   = pc_same ? STALL_W'(stall_q + 1'b1) : '0;
      if (tohost_store && memIn[0]) begin
        if (memIn == 32'd1) begin
          state_d = S_PASS;
        end else begin
          state_d = S_FAIL;
          tn_d    = memIn[31:1];
        end
      end else if (cyc_q == 32'(TIMEOUT_CYCLES - 1)) begin
        state_d = S_TIMEOUT;
        hang_d  = 1'b0;
      end else if (pc_same && (stall_q == STALL_W'(STALL_CYCLES - 1))) begin
        state_d = S_TIMEOUT;
        hang_d  = 1'b1;
      end else begin
        cyc_d = cyc_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cyc_q     <= 32'd0;
      tn_q      <= 31'd0;
      stall_q   <= '0;
      last_pc_q <= 32'd0;
      hang_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      tn_q      <= tn_d;
      stall_q   <= stall_d;
      last_pc_q <= last_pc_d;
      hang_q    <= hang_d;
      done_q    <= (state_d == S_PASS) || (state_d == S_FAIL) || (state_d == S_TIMEOUT);
      pass_q    <= (state_d == S_PASS);
      fail_q    <= (state_d == S_FAIL);
      timeout_q <= (state_d == S_TIMEOUT);
    end
  end

  assign done       = done_q;
  assign pass       = pass_q;
  assign fail       = fail_q;
  assign timeout    = timeout_q;
  assign hang       = hang_q;
  assign testNum    = tn_q;
  assign cycleCount = cyc_q;

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Randomized plus directed bench for riscv_test_monitor; two instances with
// different watchdog/stall limits share one stimulus and are checked against a model.
module tb_riscv_test_monitor;

  localparam logic [31:0] TOHOST = 32'h0000_1000;
  localparam int unsigned T_LONG = 400;
  localparam int unsigned S_LONG = 32;
  localparam int unsigned T_SHORT = 20;
  localparam int unsigned S_SHORT = 8;

  logic        clk = 1'b0;
  logic        reset, start, memWr;
  logic [31:0] memAddr, memIn, PC;
  logic [3:0]  wrMask;
  logic        hold_pc;

  logic [1:0]  done_o, pass_o, fail_o, timeout_o, hang_o;
  logic [30:0] tn_o  [2];
  logic [31:0] cyc_o [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  riscv_test_monitor #(.TOHOST_ADDR(TOHOST), .TIMEOUT_CYCLES(T_LONG), .STALL_CYCLES(S_LONG)) u_long (
    .clk(clk), .reset(reset), .start(start), .memWr(memWr), .memAddr(memAddr),
    .memIn(memIn), .wrMask(wrMask), .PC(PC), .done(done_o[0]), .pass(pass_o[0]),
    .fail(fail_o[0]), .timeout(timeout_o[0]), .hang(hang_o[0]), .testNum(tn_o[0]),
    .cycleCount(cyc_o[0]));

  riscv_test_monitor #(.TOHOST_ADDR(TOHOST), .TIMEOUT_CYCLES(T_SHORT), .STALL_CYCLES(S_SHORT)) u_short (
    .clk(clk), .reset(reset), .start(start), .memWr(memWr), .memAddr(memAddr),
    .memIn(memIn), .wrMask(wrMask), .PC(PC), .done(done_o[1]), .pass(pass_o[1]),
    .fail(fail_o[1]), .timeout(timeout_o[1]), .hang(hang_o[1]), .testNum(tn_o[1]),
    .cycleCount(cyc_o[1]));

  // Model: verdict 0=idle 1=run 2=pass 3=fail 4=timeout; 'same' is the length of
  // the current run of cycles whose PC equals the previous cycle's PC.
  typedef struct {
    int          verdict;
    bit          hang;
    int unsigned cyc;
    logic [30:0] tn;
    logic [31:0] prev_pc;
    int unsigned same;
  } mdl_t;

  mdl_t m [2];

  function automatic mdl_t mdl_reset();
    mdl_t x;
    x.verdict = 0; x.hang = 0; x.cyc = 0; x.tn = '0; x.prev_pc = '0; x.same = 0;
    return x;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t x, input int unsigned tlim, input int unsigned slim);
    mdl_t y = x;
    if (start) begin
      y = mdl_reset();
      y.verdict = 1;
      y.prev_pc = PC;
      return y;
    end
    if (x.verdict != 1) return y;
    y.same = (PC == x.prev_pc) ? x.same + 1 : 0;
    y.prev_pc = PC;
    if (memWr && memAddr == TOHOST && wrMask == 4'hF && (memIn % 2 == 1)) begin
      if (memIn == 1) y.verdict = 2;
      else begin
        y.verdict = 3;
        y.tn = 31'(memIn / 2);
      end
    end else if (x.cyc + 1 == tlim) begin
      y.verdict = 4;
    end else if (y.same == slim) begin
      y.verdict = 4;
      y.hang = 1;
    end else begin
      y.cyc = x.cyc + 1;
    end
    return y;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("u%0d.done", i), 32'(done_o[i]), 32'(m[i].verdict >= 2));
      check($sformatf("u%0d.pass", i), 32'(pass_o[i]), 32'(m[i].verdict == 2));
      check($sformatf("u%0d.fail", i), 32'(fail_o[i]), 32'(m[i].verdict == 3));
      check($sformatf("u%0d.timeout", i), 32'(timeout_o[i]), 32'(m[i].verdict == 4));
      check($sformatf("u%0d.hang", i), 32'(hang_o[i]), 32'(m[i].hang));
      check($sformatf("u%0d.testNum", i), 32'(tn_o[i]), 32'(m[i].tn));
      check($sformatf("u%0d.cycleCount", i), cyc_o[i], m[i].cyc);
    end
  endtask

  // One clock: step models on the edge, compare on the falling edge, then advance PC.
  task automatic cycle();
    @(posedge clk);
    if (reset) begin
      m[0] = mdl_reset();
      m[1] = mdl_reset();
    end else begin
      m[0] = mdl_step(m[0], T_LONG, S_LONG);
      m[1] = mdl_step(m[1], T_SHORT, S_SHORT);
    end
    @(negedge clk);
    compare_all();
    if (!hold_pc) PC = PC + 32'd4;
  endtask

  task automatic bus(input logic wr, input logic [31:0] data, input logic [3:0] mask);
    memWr = wr; memAddr = TOHOST; memIn = data; wrMask = mask;
  endtask

  task automatic do_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; memWr = 1'b0; memAddr = '0; memIn = '0;
    wrMask = '0; PC = 32'h200; hold_pc = 1'b0;
    m[0] = mdl_reset();
    m[1] = mdl_reset();
    repeat (3) cycle();
    check("reset_done", 32'(done_o[0]), 32'd0);
    reset = 1'b0;
    cycle();

    // Pass at RUN cycle 50, then hold
    do_start();
    repeat (50) cycle();
    bus(1'b1, 32'h1, 4'hF);
    cycle();
    bus(1'b0, 32'h0, 4'h0);
    check("tp1_pass", 32'(pass_o[0]), 32'd1);
    check("tp1_cyc", cyc_o[0], 32'd50);
    repeat (100) cycle();
    check("tp1_hold", 32'(pass_o[0]), 32'd1);

    // Even and partial-mask stores ignored; odd 7 fails test 3
    do_start();
    bus(1'b1, 32'h2, 4'hF);
    cycle();
    check("tp2_even_ignored", 32'(done_o[0]), 32'd0);
    bus(1'b1, 32'h1, 4'h1);
    cycle();
    check("tp2_mask_ignored", 32'(done_o[0]), 32'd0);
    bus(1'b1, 32'h7, 4'hF);
    cycle();
    bus(1'b0, 32'h0, 4'h0);
    check("tp2_fail", 32'(fail_o[0]), 32'd1);
    check("tp2_testNum", 32'(tn_o[0]), 32'd3);

    // Watchdog on the short instance
    do_start();
    repeat (19) cycle();
    check("tp3_not_yet", 32'(timeout_o[1]), 32'd0);
    cycle();
    check("tp3_timeout", 32'(timeout_o[1]), 32'd1);
    check("tp3_hang", 32'(hang_o[1]), 32'd0);
    check("tp3_cyc", cyc_o[1], 32'd19);

    // PC stall on the short instance
    hold_pc = 1'b1;
    PC = 32'h100;
    do_start();
    repeat (7) cycle();
    check("tp4_not_yet", 32'(timeout_o[1]), 32'd0);
    cycle();
    check("tp4_timeout", 32'(timeout_o[1]), 32'd1);
    check("tp4_hang", 32'(hang_o[1]), 32'd1);
    check("tp4_pass", 32'(pass_o[1]), 32'd0);
    hold_pc = 1'b0;

    // Asynchronous reset mid-run
    do_start();
    repeat (30) cycle();
    #2 reset = 1'b1;
    #1;
    m[0] = mdl_reset();
    m[1] = mdl_reset();
    check("tp5_async_cyc", cyc_o[0], 32'd0);
    compare_all();
    cycle();
    reset = 1'b0;
    bus(1'b1, 32'h1, 4'hF);
    cycle();
    check("tp5_idle_ignores", 32'(done_o[0]), 32'd0);
    bus(1'b0, 32'h0, 4'h0);

    // start beats a same-cycle store in PASS
    do_start();
    bus(1'b1, 32'h1, 4'hF);
    cycle();
    check("tp6_pass", 32'(pass_o[0]), 32'd1);
    bus(1'b1, 32'h3, 4'hF);
    do_start();
    check("tp6_restart_done", 32'(done_o[0]), 32'd0);
    check("tp6_restart_cyc", cyc_o[0], 32'd0);
    cycle();
    bus(1'b0, 32'h0, 4'h0);
    check("tp6_fail", 32'(fail_o[0]), 32'd1);
    check("tp6_testNum", 32'(tn_o[0]), 32'd1);

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      int unsigned r;
      start   = ($urandom_range(0, 79) == 0);
      reset   = ($urandom_range(0, 599) == 0);
      memWr   = ($urandom_range(0, 6) == 0);
      memAddr = ($urandom_range(0, 9) < 7) ? TOHOST : TOHOST + 32'd4;
      wrMask  = ($urandom_range(0, 4) != 0) ? 4'hF : 4'($urandom_range(0, 14));
      r = $urandom_range(0, 5);
      memIn   = (r == 0) ? 32'd0 : (r == 1) ? 32'd1 : (r == 2) ? 32'd2 :
                (r == 3) ? 32'd3 : (r == 4) ? 32'd7 : $urandom;
      if ($urandom_range(0, 29) == 0) hold_pc = ~hold_pc;
      if (hold_pc && $urandom_range(0, 19) == 0) PC = PC + 32'd4;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
